// File: rtl/pacman_spawn_pkg.sv
// Shared types and constants for bonus-fruit spawning: FSM states, coordinate
// and tile widths, and the pixel-to-tile snap used by spawner and collision logic.
package pacman_spawn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CHECK  = 2'd2,
        ACTIVE = 2'd3
    } spawn_state_e;

    localparam int COORD_MSB      = 9;
    localparam int TILE_SHIFT_DEF = 4;
    localparam int COORD_W        = COORD_MSB + 1;
    localparam int TILE_W         = COORD_W - TILE_SHIFT_DEF;
    localparam int LIFE_W         = 10;

    // Callers truncate the result to their own tile width.
    function automatic logic [31:0] tile_of(input logic [31:0] coord, input int unsigned shift);
        return coord >> shift;
    endfunction

endpackage

// File: rtl/fruit_lifetime_timer.sv
// Loadable frame-counted down-counter; done flags the tick that takes it from 1 to 0.
module fruit_lifetime_timer
    import pacman_spawn_pkg::*;
#(
    parameter int W = LIFE_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         clear,
    input  logic         enable,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count_r;

    // Remaining-frames counter: clear beats load, load beats decrement.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (enable && tick && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Combinational so the owner can register its expiry pulse on the same edge.
    assign done = enable && tick && (count_r == W'(1));

endmodule

// File: rtl/fruit_spawner.sv
// Turns random pixel coordinates into a legal on-maze fruit position, retrying on
// walls or Pac-Man's tile, then holds the fruit for a frame-counted lifetime.
module fruit_spawner
    import pacman_spawn_pkg::*;
#(
    parameter int N          = COORD_MSB,
    parameter int TILE_SHIFT = TILE_SHIFT_DEF,
    parameter int MAX_TRIES  = 8,
    parameter int LIFETIME   = 600
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
    input  logic                    spawn_req,
    input  logic [N:0]              X_rand,
    input  logic [N:0]              Y_rand,
    input  logic [N:0]              pac_x,
    input  logic [N:0]              pac_y,
    output logic                    wall_rd,
    output logic [N-TILE_SHIFT:0]   wall_tx,
    output logic [N-TILE_SHIFT:0]   wall_ty,
    input  logic                    wall_hit,
    input  logic                    eaten,
    output logic                    fruit_active,
    output logic [N:0]              fruit_x,
    output logic [N:0]              fruit_y,
    output logic                    spawn_fail,
    output logic                    expired
);

    localparam int CW    = N + 1;
    localparam int TW    = N + 1 - TILE_SHIFT;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [CW-1:0]    CENTRE_OFF = CW'(2 ** (TILE_SHIFT - 1));
    localparam logic [TRY_W-1:0] LAST_TRY   = TRY_W'(MAX_TRIES - 1);

    spawn_state_e      state_r, state_n;
    logic [TW-1:0]     ctx_r, cty_r, ctx_n, cty_n;
    logic [TRY_W-1:0]  try_r, try_n;
    logic              wall_rd_r, fruit_active_r, spawn_fail_r, expired_r;
    logic [CW-1:0]     fruit_x_r, fruit_y_r;
    logic [TW-1:0]     rand_tx_s, rand_ty_s, pac_tx_s, pac_ty_s;
    logic              reject_s, accept_s, fail_s, drop_s, expire_s, timer_done_s;

    assign rand_tx_s = TW'(tile_of(32'(X_rand), TILE_SHIFT));
    assign rand_ty_s = TW'(tile_of(32'(Y_rand), TILE_SHIFT));
    assign pac_tx_s  = TW'(tile_of(32'(pac_x), TILE_SHIFT));
    assign pac_ty_s  = TW'(tile_of(32'(pac_y), TILE_SHIFT));
    assign reject_s  = wall_hit || ((ctx_r == pac_tx_s) && (cty_r == pac_ty_s));

    // Next-state and per-cycle event decode.
    always_comb begin
        state_n  = state_r;
        ctx_n    = ctx_r;
        cty_n    = cty_r;
        try_n    = try_r;
        accept_s = 1'b0;
        fail_s   = 1'b0;
        drop_s   = 1'b0;
        expire_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (spawn_req) begin
                    ctx_n   = rand_tx_s;
                    cty_n   = rand_ty_s;
                    try_n   = {TRY_W{1'b0}};
                    state_n = SAMPLE;
                end else begin
                    state_n = IDLE;
                end
            end
            SAMPLE: begin
                state_n = CHECK;
            end
            CHECK: begin
                if (!reject_s) begin
                    accept_s = 1'b1;
                    state_n  = ACTIVE;
                end else if (try_r == LAST_TRY) begin
                    fail_s  = 1'b1;
                    state_n = IDLE;
                end else begin
                    ctx_n   = rand_tx_s;
                    cty_n   = rand_ty_s;
                    try_n   = try_r + TRY_W'(1);
                    state_n = SAMPLE;
                end
            end
            ACTIVE: begin
                if (eaten) begin
                    drop_s  = 1'b1;
                    state_n = IDLE;
                end else if (timer_done_s) begin
                    expire_s = 1'b1;
                    state_n  = IDLE;
                end else begin
                    state_n = ACTIVE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, candidate tile and try count.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            ctx_r   <= {TW{1'b0}};
            cty_r   <= {TW{1'b0}};
            try_r   <= {TRY_W{1'b0}};
        end else begin
            state_r <= state_n;
            ctx_r   <= ctx_n;
            cty_r   <= cty_n;
            try_r   <= try_n;
        end
    end

    // Registered outputs; the ROM strobe is high exactly while in SAMPLE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wall_rd_r      <= 1'b0;
            spawn_fail_r   <= 1'b0;
            expired_r      <= 1'b0;
            fruit_active_r <= 1'b0;
            fruit_x_r      <= {CW{1'b0}};
            fruit_y_r      <= {CW{1'b0}};
        end else begin
            wall_rd_r    <= (state_n == SAMPLE);
            spawn_fail_r <= fail_s;
            expired_r    <= expire_s;
            if (accept_s) begin
                fruit_active_r <= 1'b1;
                fruit_x_r      <= {ctx_r, {TILE_SHIFT{1'b0}}} + CENTRE_OFF;
                fruit_y_r      <= {cty_r, {TILE_SHIFT{1'b0}}} + CENTRE_OFF;
            end else if (drop_s || expire_s) begin
                fruit_active_r <= 1'b0;
            end else begin
                fruit_active_r <= fruit_active_r;
            end
        end
    end

    fruit_lifetime_timer #(.W(LIFE_W)) u_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (accept_s),
        .load_value (LIFE_W'(LIFETIME)),
        .clear      (drop_s),
        .enable     ((state_r == ACTIVE) && !eaten),
        .tick       (frame_tick),
        .done       (timer_done_s)
    );

    assign wall_rd      = wall_rd_r;
    assign wall_tx      = ctx_r;
    assign wall_ty      = cty_r;
    assign fruit_active = fruit_active_r;
    assign fruit_x      = fruit_x_r;
    assign fruit_y      = fruit_y_r;
    assign spawn_fail   = spawn_fail_r;
    assign expired      = expired_r;

endmodule

// File: tb/tb_fruit_spawner.sv
// Self-checking bench for fruit_spawner: directed scenarios plus randomized spawns
// compared against a tile-arithmetic reference model and a behavioural wall ROM.
module tb_fruit_spawner;

    localparam int MT = 8;
    localparam int LT = 3;

    logic       Clk = 1'b0, Reset = 1'b0;
    logic       frame_tick = 1'b0, spawn_req = 1'b0, wall_hit = 1'b0, eaten = 1'b0;
    logic [9:0] X_rand = 10'd0, Y_rand = 10'd0, pac_x = 10'd0, pac_y = 10'd0;
    logic       wall_rd, fruit_active, spawn_fail, expired;
    logic [5:0] wall_tx, wall_ty;
    logic [9:0] fruit_x, fruit_y;

    fruit_spawner #(.N(9), .TILE_SHIFT(4), .MAX_TRIES(MT), .LIFETIME(LT)) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .spawn_req(spawn_req),
        .X_rand(X_rand), .Y_rand(Y_rand), .pac_x(pac_x), .pac_y(pac_y),
        .wall_rd(wall_rd), .wall_tx(wall_tx), .wall_ty(wall_ty), .wall_hit(wall_hit),
        .eaten(eaten), .fruit_active(fruit_active), .fruit_x(fruit_x), .fruit_y(fruit_y),
        .spawn_fail(spawn_fail), .expired(expired)
    );

    always #5 Clk = ~Clk;

    bit wall_mem [0:63][0:63];
    bit wall_all = 1'b0;
    int total = 0, bad = 0, rd_count = 0;
    int cx [MT];
    int cy [MT];

    // Synchronous wall ROM and strobe counter.
    always @(posedge Clk) begin
        wall_hit <= wall_rd && (wall_all || wall_mem[wall_ty][wall_tx]);
        if (wall_rd) rd_count++;
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_walls();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                wall_mem[r][c] = 1'b0;
        wall_all = 1'b0;
    endtask

    // Runs one spawn over candidates cx/cy; expectations come from tile arithmetic.
    task automatic run_spawn(input int px, input int py, input bit hold_req, output bit accepted);
        int rd0, tries;
        bit rej;
        accepted = 1'b0;
        tries = 0;
        pac_x = 10'(px); pac_y = 10'(py);
        X_rand = 10'(cx[0]); Y_rand = 10'(cy[0]);
        spawn_req = 1'b1;
        rd0 = rd_count;
        cyc();
        if (!hold_req) spawn_req = 1'b0;
        for (int i = 0; i < MT; i++) begin
            total++;
            if (wall_rd !== 1'b1 || wall_tx !== 6'(cx[i] / 16) || wall_ty !== 6'(cy[i] / 16)) begin
                bad++;
                $display("FAIL sample_addr try %0d: got rd=%b tile=(%0d,%0d) want rd=1 tile=(%0d,%0d)",
                         i, wall_rd, wall_tx, wall_ty, cx[i] / 16, cy[i] / 16);
            end
            rej = wall_all || wall_mem[cy[i] / 16][cx[i] / 16] ||
                  ((cx[i] / 16 == px / 16) && (cy[i] / 16 == py / 16));
            if (i + 1 < MT) begin
                X_rand = 10'(cx[i + 1]); Y_rand = 10'(cy[i + 1]);
            end
            cyc();
            total++;
            if (wall_rd !== 1'b0) begin
                bad++;
                $display("FAIL check_rd_low try %0d: got %b want 0", i, wall_rd);
            end
            cyc();
            tries = i + 1;
            if (!rej) begin
                accepted = 1'b1;
                total++;
                if (fruit_active !== 1'b1 || fruit_x !== 10'((cx[i] / 16) * 16 + 8) ||
                    fruit_y !== 10'((cy[i] / 16) * 16 + 8) || spawn_fail !== 1'b0) begin
                    bad++;
                    $display("FAIL accept try %0d: got act=%b xy=(%0d,%0d) want act=1 xy=(%0d,%0d)",
                             i, fruit_active, fruit_x, fruit_y, (cx[i] / 16) * 16 + 8, (cy[i] / 16) * 16 + 8);
                end
                break;
            end else if (i == MT - 1) begin
                total++;
                if (spawn_fail !== 1'b1 || fruit_active !== 1'b0) begin
                    bad++;
                    $display("FAIL spawn_fail: got fail=%b act=%b want fail=1 act=0", spawn_fail, fruit_active);
                end
            end else begin
                total++;
                if (spawn_fail !== 1'b0 || fruit_active !== 1'b0) begin
                    bad++;
                    $display("FAIL retry try %0d: got fail=%b act=%b want 0 0", i, spawn_fail, fruit_active);
                end
            end
        end
        spawn_req = 1'b0;
        total++;
        if (rd_count - rd0 != tries) begin
            bad++;
            $display("FAIL strobe_count: got %0d want %0d", rd_count - rd0, tries);
        end
        if (!accepted) begin
            cyc();
            total++;
            if (spawn_fail !== 1'b0 || wall_rd !== 1'b0) begin
                bad++;
                $display("FAIL fail_pulse_width: got fail=%b rd=%b want 0 0", spawn_fail, wall_rd);
            end
        end
    endtask

    task automatic eat_fruit();
        eaten = 1'b1;
        cyc();
        eaten = 1'b0;
        total++;
        if (fruit_active !== 1'b0 || expired !== 1'b0) begin
            bad++;
            $display("FAIL eaten: got act=%b exp=%b want 0 0", fruit_active, expired);
        end
    endtask

    task automatic test_reset();
        bit acc;
        #1;
        total++;
        if (fruit_active !== 1'b0 || fruit_x !== 10'd0 || fruit_y !== 10'd0 || spawn_fail !== 1'b0 ||
            expired !== 1'b0 || wall_rd !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got act=%b x=%0d y=%0d fail=%b exp=%b rd=%b want all 0",
                     fruit_active, fruit_x, fruit_y, spawn_fail, expired, wall_rd);
        end
        cyc(); cyc();
        Reset = 1'b1;
        cyc();
        clear_walls();
        cx[0] = 200; cy[0] = 300;
        run_spawn(40, 40, 1'b0, acc);
        #2 Reset = 1'b0;
        #1;
        total++;
        if (fruit_active !== 1'b0 || expired !== 1'b0 || spawn_fail !== 1'b0 || fruit_x !== 10'd0) begin
            bad++;
            $display("FAIL reset_mid_active: got act=%b exp=%b fail=%b x=%0d want 0 0 0 0",
                     fruit_active, expired, spawn_fail, fruit_x);
        end
        cyc();
        Reset = 1'b1;
        for (int t = 0; t < 4; t++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            total++;
            if (fruit_active !== 1'b0 || expired !== 1'b0 || wall_rd !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle: got act=%b exp=%b rd=%b want 0 0 0", fruit_active, expired, wall_rd);
            end
        end
        X_rand = 10'd200; Y_rand = 10'd300; spawn_req = 1'b1;
        cyc();
        spawn_req = 1'b0;
        #2 Reset = 1'b0;
        #1;
        total++;
        if (wall_rd !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_spawn: got rd=%b want 0", wall_rd);
        end
        cyc();
        Reset = 1'b1;
        cyc(); cyc();
        total++;
        if (fruit_active !== 1'b0 || spawn_fail !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_pulse: got act=%b fail=%b want 0 0", fruit_active, spawn_fail);
        end
    endtask

    task automatic test_basic_spawn();
        bit acc;
        clear_walls();
        cx[0] = 200; cy[0] = 300;
        run_spawn(40, 40, 1'b0, acc);
        eat_fruit();
    endtask

    task automatic test_wall_retry();
        bit acc;
        clear_walls();
        wall_mem[18][8] = 1'b1;
        cx[0] = 130; cy[0] = 300;
        cx[1] = 200; cy[1] = 200;
        run_spawn(40, 40, 1'b0, acc);
        eat_fruit();
    endtask

    task automatic test_all_walls();
        bit acc;
        clear_walls();
        wall_all = 1'b1;
        for (int i = 0; i < MT; i++) begin
            cx[i] = 16 * i + 3; cy[i] = 100 + 16 * i;
        end
        run_spawn(40, 40, 1'b0, acc);
        wall_all = 1'b0;
    endtask

    task automatic test_pac_tile();
        bit acc;
        clear_walls();
        cx[0] = 200; cy[0] = 300;
        cx[1] = 200; cy[1] = 200;
        run_spawn(205, 290, 1'b1, acc);
        eat_fruit();
        for (int i = 0; i < MT; i++) begin
            cx[i] = 192 + i; cy[i] = 288 + 2 * i;
        end
        run_spawn(205, 290, 1'b1, acc);
    endtask

    task automatic test_lifetime(input bit eat_last);
        bit acc;
        clear_walls();
        cx[0] = 500; cy[0] = 70;
        run_spawn(40, 40, 1'b0, acc);
        for (int t = 1; t <= LT; t++) begin
            frame_tick = 1'b1;
            eaten = (eat_last && t == LT);
            cyc();
            frame_tick = 1'b0; eaten = 1'b0;
            total++;
            if (t < LT) begin
                if (fruit_active !== 1'b1 || expired !== 1'b0) begin
                    bad++;
                    $display("FAIL lifetime_tick %0d: got act=%b exp=%b want 1 0", t, fruit_active, expired);
                end
            end else if (fruit_active !== 1'b0 || expired !== !eat_last || fruit_x !== 10'd504 || fruit_y !== 10'd72) begin
                bad++;
                $display("FAIL lifetime_end eat=%b: got act=%b exp=%b xy=(%0d,%0d) want act=0 exp=%b xy=(504,72)",
                         eat_last, fruit_active, expired, fruit_x, fruit_y, !eat_last);
            end
            if (t == 1) spawn_req = 1'b1;
            cyc();
            spawn_req = 1'b0;
            total++;
            if (expired !== 1'b0 || wall_rd !== 1'b0) begin
                bad++;
                $display("FAIL lifetime_gap %0d: got exp=%b rd=%b want 0 0", t, expired, wall_rd);
            end
        end
    endtask

    task automatic test_random();
        bit acc;
        for (int n = 0; n < 15; n++) begin
            clear_walls();
            for (int r = 0; r < 64; r++)
                for (int c = 0; c < 64; c++)
                    wall_mem[r][c] = ($urandom_range(0, 99) < 55);
            for (int i = 0; i < MT; i++) begin
                cx[i] = $urandom_range(0, 1015);
                cy[i] = $urandom_range(0, 1015);
            end
            if ($urandom_range(0, 3) == 0) begin
                cx[1] = cx[0]; cy[1] = cy[0];
            end
            run_spawn($urandom_range(0, 1015), $urandom_range(0, 1015), 1'b0, acc);
            if (acc) eat_fruit();
        end
    endtask

    initial begin
        test_reset();
        test_basic_spawn();
        test_wall_retry();
        test_all_walls();
        test_pac_tile();
        test_lifetime(1'b0);
        test_lifetime(1'b1);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
